// File: rtl/lab3_mem_pkg.sv
// Shared memory-message definitions for the lab3 cache bank router: widths, field offsets and the bank-select hash.
// Bank hashing is selected by LAB3_MEM_BANK_ROUTER_XOR_HASH_EN (defined: XOR fold, undefined: plain slice).
package lab3_mem_pkg;

   localparam int c_req_w          = 77;
   localparam int c_resp_w         = 47;
   localparam int c_addr_w         = 32;
   localparam int c_req_type_lsb   = 74;
   localparam int c_req_opaque_lsb = 66;
   localparam int c_req_addr_lsb   = 34;
   localparam int c_req_len_lsb    = 32;
   localparam int c_req_data_lsb   = 0;
   localparam int c_resp_type_lsb  = 44;
   localparam int c_resp_opq_lsb   = 36;
   localparam int c_resp_test_lsb  = 34;
   localparam int c_resp_len_lsb   = 32;
   localparam int c_resp_data_lsb  = 0;

   typedef enum logic [2:0] {
      MEM_TYPE_READ  = 3'd0,
      MEM_TYPE_WRITE = 3'd1,
      MEM_TYPE_INIT  = 3'd2
   } mem_type_e;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4b_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4b_t;

   // addr_nib carries addr[7:4]; only the low log2(num_banks) bits of the result are meaningful.
   function automatic logic [1:0] bank_sel(input logic [3:0] addr_nib, input int num_banks);
      logic [1:0] sel;
      sel = 2'd0;
      case (num_banks)
`ifdef LAB3_MEM_BANK_ROUTER_XOR_HASH_EN
         2: sel = {1'b0, addr_nib[0] ^ addr_nib[1]};
         4: sel = addr_nib[1:0] ^ addr_nib[3:2];
`else
         2: sel = {1'b0, addr_nib[0]};
         4: sel = addr_nib[1:0];
`endif
         default: sel = 2'd0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/lab3_mem_cache_bank_router_if.sv
// Processor-side and bank-side handshake bundle for the cache bank router.
// 'slave' is the router's view, 'master' is the surrounding processor/bank environment.
interface lab3_mem_cache_bank_router_if #(
   parameter int p_num_banks = 4
);
   import lab3_mem_pkg::*;

   logic [c_req_w-1:0]              cachereq_msg;
   logic                            cachereq_val;
   logic                            cachereq_rdy;
   logic [c_resp_w-1:0]             cacheresp_msg;
   logic                            cacheresp_val;
   logic                            cacheresp_rdy;
   logic [c_req_w-1:0]              bankreq_msg;
   logic [p_num_banks-1:0]          bankreq_val;
   logic [p_num_banks-1:0]          bankreq_rdy;
   logic [c_resp_w*p_num_banks-1:0] bankresp_msg;
   logic [p_num_banks-1:0]          bankresp_val;
   logic [p_num_banks-1:0]          bankresp_rdy;

   modport slave (
      input  cachereq_msg, cachereq_val, cacheresp_rdy, bankreq_rdy, bankresp_msg, bankresp_val,
      output cachereq_rdy, cacheresp_msg, cacheresp_val, bankreq_msg, bankreq_val, bankresp_rdy
   );

   modport master (
      output cachereq_msg, cachereq_val, cacheresp_rdy, bankreq_rdy, bankresp_msg, bankresp_val,
      input  cachereq_rdy, cacheresp_msg, cacheresp_val, bankreq_msg, bankreq_val, bankresp_rdy
   );

endinterface

// File: rtl/lab3_mem_bank_order_fifo.sv
// Order FIFO of bank ids for the cache bank router; head is read combinationally.
// Reset gates full/empty immediately so outputs look empty during the reset cycle.
module lab3_mem_bank_order_fifo #(
   parameter int p_width = 2,
   parameter int p_depth = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_enq_val,
   output logic               o_enq_rdy,
   input  logic [p_width-1:0] i_enq_data,
   output logic               o_deq_val,
   input  logic               i_deq_rdy,
   output logic [p_width-1:0] o_head,
   output logic               o_full,
   output logic               o_empty
);

   localparam int p_ptr_w = $clog2(p_depth);
   localparam int p_cnt_w = p_ptr_w + 1;

   logic [p_width-1:0] r_mem [p_depth];
   logic [p_ptr_w-1:0] r_wr_ptr;
   logic [p_ptr_w-1:0] r_rd_ptr;
   logic [p_cnt_w-1:0] r_count;
   logic               w_enq_fire;
   logic               w_deq_fire;

   assign o_full     = (r_count == p_cnt_w'(p_depth)) && !reset;
   assign o_empty    = (r_count == '0) || reset;
   assign o_enq_rdy  = !o_full;
   assign o_deq_val  = !o_empty;
   assign o_head     = r_mem[r_rd_ptr];
   assign w_enq_fire = i_enq_val && o_enq_rdy && !reset;
   assign w_deq_fire = i_deq_rdy && o_deq_val;

   always_ff @(posedge clk) begin
      if (w_enq_fire) begin
         r_mem[r_wr_ptr] <= i_enq_data;
      end
   end

   // Depth is a power of two, so pointer increments wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_deq_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_enq_fire && !w_deq_fire) begin
            r_count <= r_count + 1'b1;
         end else if (!w_enq_fire && w_deq_fire) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/lab3_mem_cache_bank_router.sv
// Steers cache requests to banks by address and returns bank responses in request order.
// Optional XOR bank hashing: define LAB3_MEM_BANK_ROUTER_XOR_HASH_EN.
module lab3_mem_cache_bank_router
   import lab3_mem_pkg::*;
#(
   parameter int p_num_banks   = 4,
   parameter int p_order_depth = 4
) (
   input  logic clk,
   input  logic reset,
   lab3_mem_cache_bank_router_if.slave bus
);

   localparam int p_sel_w = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;

   logic [1:0]          w_sel_full;
   logic [p_sel_w-1:0]  w_sel;
   logic [p_sel_w-1:0]  w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_enq_rdy;
   logic                w_deq_val;
   logic                w_enq_val;
   logic                w_deq_rdy;
   logic [c_resp_w-1:0] w_resp_slice [p_num_banks];

   assign w_sel_full = bank_sel(bus.cachereq_msg[c_req_addr_lsb+4 +: 4], p_num_banks);
   assign w_sel      = w_sel_full[p_sel_w-1:0];

   assign bus.bankreq_msg  = bus.cachereq_msg;
   assign bus.cachereq_rdy = bus.bankreq_rdy[w_sel] && w_enq_rdy;
   assign w_enq_val        = bus.cachereq_val && bus.bankreq_rdy[w_sel];

   assign bus.cacheresp_val = w_deq_val && bus.bankresp_val[w_head];
   assign bus.cacheresp_msg = w_resp_slice[w_head];
   assign w_deq_rdy         = bus.cacheresp_rdy && bus.bankresp_val[w_head];

   genvar gi;
   generate
      for (gi = 0; gi < p_num_banks; gi++) begin : g_bank
         assign bus.bankreq_val[gi]  = bus.cachereq_val && (w_sel == p_sel_w'(gi)) && !w_full;
         assign bus.bankresp_rdy[gi] = (w_head == p_sel_w'(gi)) && !w_empty && bus.cacheresp_rdy;
         assign w_resp_slice[gi]     = bus.bankresp_msg[c_resp_w*gi +: c_resp_w];
      end
   endgenerate

   lab3_mem_bank_order_fifo #(
      .p_width (p_sel_w),
      .p_depth (p_order_depth)
   ) u_order_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_enq_val  (w_enq_val),
      .o_enq_rdy  (w_enq_rdy),
      .i_enq_data (w_sel),
      .o_deq_val  (w_deq_val),
      .i_deq_rdy  (w_deq_rdy),
      .o_head     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // A bank answering with no outstanding request is a protocol error; it is also never acknowledged.
   always_ff @(posedge clk) begin
      if (!reset && w_empty) begin
         assert (bus.bankresp_val == '0);
      end
   end

endmodule
